// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: single-outstanding valid/ready
// request channel plus a response strobe carrying read data or a write ack.
interface load_store_unit_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 memory-access stage: accepts one load/store from execute, drives a
// single-outstanding data-memory request, steers store lanes/strobes,
// extends load data and reports misalignment and bus timeouts.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_store,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  load_store_unit_if.master        dmem,
  output logic                     rsp_valid,
  output logic [31:0]              load_data,
  output logic                     misaligned,
  output logic                     bus_timeout,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  // Counter value seen on the last allowed REQ/WAIT cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic        is_store_q;
  logic [7:0]  tmo_cnt;

  logic        req_bad;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  // Illegal width codes and misaligned halfword/word accesses are rejected.
  always_comb begin
    req_bad = 1'b0;
    case (req_funct3)
      3'b000:         req_bad = 1'b0;
      3'b001:         req_bad = req_addr[0];
      3'b010:         req_bad = |req_addr[1:0];
      3'b100, 3'b101: req_bad = req_is_store | (req_funct3[0] & req_addr[0]);
      default:        req_bad = 1'b1;
    endcase
  end

  // Store lane replication and byte strobes; loads carry no strobes.
  always_comb begin
    st_wdata = req_wdata;
    st_wstrb = 4'b0000;
    if (req_is_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          st_wdata = {4{req_wdata[7:0]}};
          st_wstrb = 4'b0001 << req_addr[1:0];
        end
        2'b01: begin
          st_wdata = {2{req_wdata[15:0]}};
          st_wstrb = 4'b0011 << req_addr[1:0];
        end
        default: st_wstrb = 4'b1111;
      endcase
    end
  end

  // Byte/halfword extraction from the read word and sign/zero extension.
  always_comb begin
    rd_shift = dmem.dmem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rd_ext = {24'h000000, rd_shift[7:0]};
      3'b101:  rd_ext = {16'h0000, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // Transaction FSM with registered bus and completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      funct3_q            <= '0;
      lane_q              <= '0;
      is_store_q          <= 1'b0;
      tmo_cnt             <= '0;
      rsp_valid           <= 1'b0;
      load_data           <= '0;
      misaligned          <= 1'b0;
      bus_timeout         <= 1'b0;
      dmem.dmem_req_valid <= 1'b0;
      dmem.dmem_we        <= 1'b0;
      dmem.dmem_addr      <= '0;
      dmem.dmem_wdata     <= '0;
      dmem.dmem_wstrb     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q    <= req_funct3;
            lane_q      <= req_addr[1:0];
            is_store_q  <= req_is_store;
            tmo_cnt     <= '0;
            misaligned  <= req_bad;
            bus_timeout <= 1'b0;
            if (req_bad) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
            end else begin
              state               <= REQ;
              dmem.dmem_req_valid <= 1'b1;
              dmem.dmem_we        <= req_is_store;
              dmem.dmem_addr      <= {req_addr[31:2], 2'b00};
              dmem.dmem_wdata     <= st_wdata;
              dmem.dmem_wstrb     <= st_wstrb;
            end
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (tmo_cnt == TMO_LAST) begin
            state               <= DONE;
            rsp_valid           <= 1'b1;
            bus_timeout         <= 1'b1;
            dmem.dmem_req_valid <= 1'b0;
          end else if (dmem.dmem_req_ready) begin
            state               <= WAIT;
            dmem.dmem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          // A response on the timeout cycle still completes normally.
          if (dmem.dmem_rsp_valid) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            if (!is_store_q) begin
              load_data <= rd_ext;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= DONE;
            rsp_valid   <= 1'b1;
            bus_timeout <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed transactions push expected
// bus requests and completions; a memory model and a completion monitor pop
// and compare them independently of the stimulus.
module tb_load_store_unit;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        to;
    int unsigned lat;
    int unsigned acc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_timeout;
  logic        busy;

  load_store_unit_if dmem ();

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .dmem         (dmem.master),
    .rsp_valid    (rsp_valid),
    .load_data    (load_data),
    .misaligned   (misaligned),
    .bus_timeout  (bus_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned rsp_seen = 0;

  req_t exp_req[$];
  rsp_t exp_rsp[$];

  int unsigned cfg_ready_wait = 0;
  int unsigned cfg_rsp_wait   = 0;
  logic        cfg_respond    = 1'b1;
  logic [31:0] cfg_rdata      = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  task automatic mem_cfg(input int unsigned rw, input int unsigned sw, input logic resp, input logic [31:0] rd);
    cfg_ready_wait = rw;
    cfg_rsp_wait   = sw;
    cfg_respond    = resp;
    cfg_rdata      = rd;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input bit has_req, input logic [31:0] wdata_e, input logic [3:0] strb_e,
                       input logic [31:0] ld_e, input logic mis_e, input logic to_e,
                       input int unsigned lat_e, input bit expect_rsp);
    int unsigned n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_wait: req_ready=%b after 50 cycles, expected 1", req_ready);
      return;
    end
    if (has_req) exp_req.push_back('{addr: a & 32'hFFFF_FFFC, we: st, wdata: wdata_e, wstrb: strb_e});
    if (expect_rsp) exp_rsp.push_back('{ld: ld_e, mis: mis_e, to: to_e, lat: lat_e, acc: cyc + 1});
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    @(negedge clk);
    req_valid = 1'b0;
    if (expect_rsp) begin
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (busy !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL completion_wait: busy=%b after 100 cycles, expected 0", busy);
      end
    end
  endtask

  // Memory model: checks every REQ-cycle bus value, applies backpressure and responses.
  initial begin : mem_model
    bit          in_req  = 1'b0;
    bit          pending = 1'b0;
    int unsigned ready_cnt = 0;
    int unsigned rsp_cnt   = 0;
    req_t        e;
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rdata     = '0;
    forever begin
      @(negedge clk);
      dmem.dmem_req_ready = 1'b0;
      dmem.dmem_rsp_valid = 1'b0;
      if (pending) begin
        if (rsp_cnt == 0) begin
          dmem.dmem_rsp_valid = 1'b1;
          dmem.dmem_rdata     = cfg_rdata;
          pending             = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end
      if (dmem.dmem_req_valid === 1'b1) begin
        if (!in_req) begin
          in_req    = 1'b1;
          ready_cnt = cfg_ready_wait;
        end
        if (exp_req.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_dmem_req: dmem_req_valid=1 addr=0x%08h, expected no request", dmem.dmem_addr);
        end else begin
          e = exp_req[0];
          chk("dmem_addr",  dmem.dmem_addr, e.addr);
          chk("dmem_we",    32'(dmem.dmem_we), 32'(e.we));
          chk("dmem_wdata", dmem.dmem_wdata, e.wdata);
          chk("dmem_wstrb", 32'(dmem.dmem_wstrb), 32'(e.wstrb));
          if (ready_cnt == 0) begin
            dmem.dmem_req_ready = 1'b1;
            void'(exp_req.pop_front());
            in_req = 1'b0;
            if (cfg_respond) begin
              pending = 1'b1;
              rsp_cnt = cfg_rsp_wait;
            end
          end else begin
            ready_cnt--;
          end
        end
      end else if (in_req) begin
        in_req = 1'b0;
        if (exp_req.size() > 0) void'(exp_req.pop_front());
      end
    end
  end

  // Completion monitor: every rsp_valid pulse must match the oldest expected completion.
  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        rsp_seen++;
        if (exp_rsp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1, expected 0 (nothing outstanding)");
        end else begin
          r = exp_rsp.pop_front();
          chk("load_data",    load_data, r.ld);
          chk("misaligned",   32'(misaligned), 32'(r.mis));
          chk("bus_timeout",  32'(bus_timeout), 32'(r.to));
          chk("rsp_latency",  32'(cyc - r.acc + 1), 32'(r.lat));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned seen0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = '0;
    req_addr     = '0;
    req_wdata    = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",   32'(req_ready), 32'd0);
    chk("rst_busy",        32'(busy), 32'd0);
    chk("rst_rsp_valid",   32'(rsp_valid), 32'd0);
    chk("rst_dmem_valid",  32'(dmem.dmem_req_valid), 32'd0);
    chk("rst_dmem_wstrb",  32'(dmem.dmem_wstrb), 32'd0);
    chk("rst_dmem_addr",   dmem.dmem_addr, 32'd0);
    chk("rst_load_data",   load_data, 32'd0);
    chk("rst_misaligned",  32'(misaligned), 32'd0);
    chk("rst_bus_timeout", 32'(bus_timeout), 32'd0);
    rst = 1'b0;
    #1 chk("req_ready_after_rst", 32'(req_ready), 32'd1);

    // Loads, zero-wait memory
    mem_cfg(0, 0, 1'b1, 32'h80FF_1234);
    issue(1'b0, 3'b000, 32'h0000_1003, '0, 1'b1, '0, 4'b0000, 32'hFFFF_FF80, 1'b0, 1'b0, 3, 1'b1);
    mem_cfg(0, 0, 1'b1, 32'hBEEF_0000);
    issue(1'b0, 3'b101, 32'h0000_2002, '0, 1'b1, '0, 4'b0000, 32'h0000_BEEF, 1'b0, 1'b0, 3, 1'b1);
    mem_cfg(0, 0, 1'b1, 32'h0000_F100);
    issue(1'b0, 3'b100, 32'h0000_1001, '0, 1'b1, '0, 4'b0000, 32'h0000_00F1, 1'b0, 1'b0, 3, 1'b1);

    // Stores leave load_data alone even though the ack carries data
    mem_cfg(0, 0, 1'b1, 32'hDEAD_BEEF);
    issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 1'b1, 32'hA5A5_A5A5, 4'b0010, 32'h0000_00F1, 1'b0, 1'b0, 3, 1'b1);
    issue(1'b1, 3'b001, 32'h0000_3002, 32'h1234_5678, 1'b1, 32'h5678_5678, 4'b1100, 32'h0000_00F1, 1'b0, 1'b0, 3, 1'b1);
    issue(1'b1, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0000_00F1, 1'b0, 1'b0, 3, 1'b1);

    // Misaligned and illegal width codes
    issue(1'b0, 3'b010, 32'h0000_4002, '0, 1'b0, '0, 4'b0000, 32'h0000_00F1, 1'b1, 1'b0, 1, 1'b1);
    issue(1'b0, 3'b011, 32'h0000_4000, '0, 1'b0, '0, 4'b0000, 32'h0000_00F1, 1'b1, 1'b0, 1, 1'b1);
    issue(1'b1, 3'b001, 32'h0000_3003, 32'h1111_2222, 1'b0, '0, 4'b0000, 32'h0000_00F1, 1'b1, 1'b0, 1, 1'b1);
    issue(1'b1, 3'b100, 32'h0000_3000, 32'h1111_2222, 1'b0, '0, 4'b0000, 32'h0000_00F1, 1'b1, 1'b0, 1, 1'b1);

    // Backpressure: ready low for 5 REQ cycles
    mem_cfg(5, 0, 1'b1, 32'h8001_0000);
    issue(1'b0, 3'b001, 32'h0000_5002, '0, 1'b1, '0, 4'b0000, 32'hFFFF_8001, 1'b0, 1'b0, 8, 1'b1);
    mem_cfg(0, 0, 1'b1, 32'h1234_5678);
    issue(1'b0, 3'b010, 32'h0000_6000, '0, 1'b1, '0, 4'b0000, 32'h1234_5678, 1'b0, 1'b0, 3, 1'b1);

    // Timeouts: no response in WAIT, never ready in REQ, response on the timeout cycle
    mem_cfg(0, 0, 1'b0, 32'hFFFF_FFFF);
    issue(1'b0, 3'b010, 32'h0000_7000, '0, 1'b1, '0, 4'b0000, 32'h1234_5678, 1'b0, 1'b1, 9, 1'b1);
    mem_cfg(100, 0, 1'b0, 32'hFFFF_FFFF);
    issue(1'b0, 3'b010, 32'h0000_7010, '0, 1'b1, '0, 4'b0000, 32'h1234_5678, 1'b0, 1'b1, 9, 1'b1);
    mem_cfg(0, 6, 1'b1, 32'h0BAD_F00D);
    issue(1'b0, 3'b010, 32'h0000_7004, '0, 1'b1, '0, 4'b0000, 32'h0BAD_F00D, 1'b0, 1'b0, 9, 1'b1);

    // Reset while the request is still held in REQ
    mem_cfg(100, 0, 1'b0, 32'h0);
    issue(1'b0, 3'b010, 32'h0000_8000, '0, 1'b1, '0, 4'b0000, '0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("req_valid_before_rst", 32'(dmem.dmem_req_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_in_req_dmem_valid", 32'(dmem.dmem_req_valid), 32'd0);
    chk("rst_in_req_busy",       32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in WAIT with a response arriving afterwards in IDLE
    mem_cfg(0, 3, 1'b1, 32'h5555_5555);
    issue(1'b0, 3'b010, 32'h0000_8004, '0, 1'b1, '0, 4'b0000, '0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("busy_in_wait", 32'(busy), 32'd1);
    seen0 = rsp_seen;
    rst = 1'b1;
    #1;
    chk("rst_in_wait_dmem_valid", 32'(dmem.dmem_req_valid), 32'd0);
    chk("rst_in_wait_busy",       32'(busy), 32'd0);
    chk("rst_in_wait_rsp_valid",  32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("stray_rsp_ignored",   32'(rsp_seen), 32'(seen0));
    chk("load_data_after_rst", load_data, 32'd0);

    // Normal operation resumes after reset
    mem_cfg(0, 0, 1'b1, 32'h0000_007F);
    issue(1'b0, 3'b000, 32'h0000_9000, '0, 1'b1, '0, 4'b0000, 32'h0000_007F, 1'b0, 1'b0, 3, 1'b1);

    repeat (2) @(negedge clk);
    chk("exp_rsp_drained", 32'(exp_rsp.size()), 32'd0);
    chk("exp_req_drained", 32'(exp_req.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RV32 pipeline. It accepts one load or store per transaction from execute, drives a single-outstanding valid/ready data-memory port, and performs byte-lane steering and strobe generation. On loads it sign- or zero-extends the result and holds it on `load_data`, which feeds the write-back stage's memory input (`mem_in`). It detects misaligned accesses and bus timeouts and reports them to the control unit.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles allowed in REQ+WAIT before the transaction is aborted; range 1..255.

- `clk`  in  1  clock; all flops are rising-edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req_valid`  in  1  execute presents a transaction.
- `req_ready`  out  1  unit can accept a transaction; 1 only in IDLE with `rst` low.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  32  byte address (ALU result).
- `req_wdata`  in  32  rs2 store data.
- `dmem_req_valid`  out  1  memory request.
- `dmem_req_ready`  in  1  memory accepts the request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  `{addr[31:2],2'b00}`.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_wstrb`  out  4  byte strobes; 0000 on loads.
- `dmem_rsp_valid`  in  1  read data valid, or write acknowledge.
- `dmem_rdata`  in  32  read word.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `load_data`  out  32  (`arch_reg`) extended load result; held between loads.
- `misaligned`  out  1  completion flag: misaligned access or illegal `funct3`; valid with `rsp_valid`.
- `bus_timeout`  out  1  completion flag: timeout; valid with `rsp_valid`.
- `busy`  out  1  state is not IDLE.

## Operation
- **States:** IDLE, REQ, WAIT, DONE. The state and all registered outputs reset asynchronously: IDLE; `load_data`, `misaligned`, `bus_timeout`, `rsp_valid` and `dmem_*` outputs all 0.
- **Accept:** `req_valid && req_ready` captures funct3, addr, wdata and is_store into registers.
- **Illegal / misaligned:** an illegal funct3 is treated as misaligned. Misaligned means halfword with `addr[0]=1`, or word with `addr[1:0]!=0`. In either case: IDLE->DONE with `misaligned=1`, no memory request, `load_data` unchanged.
- **Legal request:** IDLE->REQ.
  - REQ asserts `dmem_req_valid`.
  - `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_wstrb` stay stable until `dmem_req_ready`; the handshake then moves REQ->WAIT.
- **WAIT:** `dmem_req_valid=0`. `dmem_rsp_valid` moves WAIT->DONE. `dmem_rsp_valid` seen in REQ or IDLE is ignored.
- **Load extraction:** `sh = dmem_rdata >> (8*addr[1:0])`.
  - LB/LBU take `sh[7:0]`; LH/LHU take `sh[15:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - The result is registered into `load_data` on the WAIT->DONE transition.
  - Stores never modify `load_data`.
- **Store steering:**
  - SB: wdata `{4{b}}`, wstrb `0001<<addr[1:0]`.
  - SH: wdata `{2{h}}`, wstrb `0011<<addr[1:0]`.
  - SW: wdata unchanged, wstrb `1111`.
- **Timeout counter:** an 8-bit counter clears on accept and increments each cycle in REQ or WAIT. When it equals `TIMEOUT_CYCLES`, the unit goes to DONE with `bus_timeout=1`, `dmem_req_valid` drops, and `load_data` is unchanged. If a response arrives in the same cycle as the timeout, the response wins and `bus_timeout=0`.
- **DONE:** `rsp_valid=1` for exactly one cycle, then IDLE. The flags are cleared when the next transaction is accepted.
- **Reset mid-transaction:** the unit returns to IDLE immediately and `dmem_req_valid` drops asynchronously. A late `dmem_rsp_valid` that arrives afterwards in IDLE is ignored.

## Timing
- Accept edge = cycle 0 (edges numbered 0,1,2...; each output value below is the one observed during the named cycle).
- Zero-wait memory (ready in the first REQ cycle, response in the following cycle):
  - `dmem_req_valid` high during cycle 1.
  - WAIT in cycle 2; rsp arrives cycle 2.
  - `rsp_valid` and `load_data` valid in cycle 3.
  - `req_ready` high again in cycle 4.
- Minimum throughput: one transaction per 4 cycles.
- Misaligned: `rsp_valid` in cycle 1, `req_ready` in cycle 2.
- All outputs are registered or decoded from state only. There are no combinational paths from `dmem_*` inputs to outputs.

## Test plan
- **LB with sign extension:** LB addr 0x1003, rdata 0x80FF_1234 -> `dmem_addr`=0x1000, `wstrb`=0000, `load_data`=0xFFFF_FF80, `rsp_valid` in cycle 3.
- **LHU:** LHU addr 0x2002, rdata 0xBEEF_0000 -> `load_data`=0x0000_BEEF.
- **Stores:** SB addr 0x3001, wdata 0x0000_00A5 -> `wdata`=0xA5A5_A5A5, `wstrb`=0010, `we`=1, and `load_data` unchanged. SH addr 0x3002 -> `wstrb`=1100.
- **Misaligned:** LW addr 0x4002 -> no `dmem_req_valid`, `misaligned=1` with `rsp_valid` in cycle 1. Also funct3=011 load -> `misaligned=1`.
- **Backpressure and timeout:**
  - `dmem_req_ready` low for 5 cycles -> request signals stable throughout, then completes normally.
  - `TIMEOUT_CYCLES`=8 with no response -> `bus_timeout=1` after 8 cycles in REQ/WAIT.
  - Response and timeout in the same cycle -> `bus_timeout=0`.
- **Reset in WAIT:** assert `rst` while in WAIT -> `dmem_req_valid`, `busy` and `rsp_valid` are 0 immediately. After deassert, a stray `dmem_rsp_valid` produces no `rsp_valid`.
